lsu_mem_arbiter: RTL
====================

# lsu_mem_arbiter

Shares the single data-memory port between the NUM_LANES load/store slots of the VLIW bundle. Each LSU lane raises a request from its execute stage. The arbiter grants one lane per cycle and drives the memory port from the granted lane. It returns read data to the owning lane one cycle later and raises `stall` to the hazard detection unit whenever any requester is left waiting.

## Interface
- NUM_LANES, 2, number of LSU lanes sharing the port (2..4)
- LANE_W, $clog2(NUM_LANES), width of lane index / round-robin pointer

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_LANES  per-lane memory request; held by lane until granted
- is_wr  in  NUM_LANES  per-lane: 1 = store, 0 = load
- addr  in  NUM_LANES*32  per-lane byte address, lane i at [32*i+31:32*i]
- wdata  in  NUM_LANES*32  per-lane store data, same packing
- gnt  out  NUM_LANES  one-hot grant, combinational
- rvalid  out  NUM_LANES  one-hot: load data for lane i valid on rdata
- rdata  out  32  load data returned from memory
- stall  out  1  to hazard detection: some request not granted this cycle
- flush  in  1  branch squash: cancel in-flight load response
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wr_en  out  1  memory write strobe
- mem_rd_en  out  1  memory read strobe
- mem_rdata  in  32  memory read data, valid cycle after mem_rd_en

## Operation
- State: rr_ptr (LANE_W bits), rd_pend (1 bit), rd_lane (LANE_W bits).
- Grant search starts at rr_ptr and wraps modulo NUM_LANES; the first lane with req=1 wins. At most one gnt bit is set. gnt=0 when req=0.
- Granted lane k drives the memory port: mem_addr=addr[k], mem_wdata=wdata[k], mem_wr_en=is_wr[k], mem_rd_en=~is_wr[k].
- With no grant: mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wdata=0.
- On a grant to lane k, rr_ptr <= (k+1) mod NUM_LANES. With no grant, rr_ptr holds.
- On a read grant, rd_pend <= 1 and rd_lane <= k. Otherwise rd_pend <= 0.
- rvalid[rd_lane] = rd_pend. rdata = mem_rdata when rd_pend=1, else 0.
- flush=1 clears rd_pend on the next edge, so no rvalid appears for a read granted in the flush cycle. flush also suppresses the rvalid of the current cycle combinationally.
- A flush does not block grants; the memory port still issues the access.
- stall = |(req & ~gnt).
- A lane whose req is still high after losing holds addr, wdata and is_wr stable until granted. Changing them before the grant is illegal; the bench asserts on it.
- A lane deasserting req before it is granted is legal; the request is dropped.

## Timing
- Grant and memory-port outputs: 0-cycle (combinational from req, rr_ptr).
- Load latency: rvalid/rdata exactly 1 cycle after the grant.
- Store: complete in the grant cycle, with no response.
- Back-to-back grants every cycle. A read in cycle n and a read in n+1 both return, in n+1 and n+2.
- Worst-case wait for a continuously requesting lane: NUM_LANES-1 cycles.
- Reset (rst=0, async): rr_ptr=0, rd_pend=0, rd_lane=0.
  - Outputs during reset: rvalid=0, rdata=0. gnt, stall and the mem_* outputs follow combinationally from req.
  - A read in flight when reset asserts is discarded.

## Configuration
- LSU_ARB_FIXED_PRIO_EN defined: lane 0 has fixed highest priority, then lane 1, and so on. rr_ptr is removed and the search always starts at lane 0.
- LSU_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.

## Test plan
- Reset, then single lane: lane 0 load, addr=0x100, mem_rdata=0xDEADBEEF next cycle -> gnt=01 in cycle 0, stall=0; rvalid=01 and rdata=0xDEADBEEF in cycle 1.
- Contention, NUM_LANES=2, both lanes request loads every cycle from reset:
  - Grants must be 01, 10, 01, 10.
  - stall=1 every cycle.
  - rvalid follows one cycle behind each grant.
- Mixed: lane 0 store (0x40, 0x12345678) and lane 1 load (0x44), both held high:
  - Cycle 0: lane 0 granted, mem_wr_en=1, stall=1.
  - Cycle 1: lane 1 granted, mem_rd_en=1, stall=0.
  - Cycle 2: rvalid=10.
- Flush: lane 1 load granted in cycle n with flush=1 -> rvalid=00 in cycle n+1. A load granted in n+1 without flush returns in n+2.
- Async reset mid-read: grant a load, deassert rst before the next edge -> rvalid=0 immediately; after release, the first grant for dual requests goes to lane 0.
- With LSU_ARB_FIXED_PRIO_EN defined, both lanes requesting continuously -> lane 0 granted every cycle, lane 1 never, stall=1.

Source files
------------

// File: rtl/lsu_mem_arbiter_if.sv
// lsu_mem_arbiter_if: per-lane LSU request bus plus the shared data-memory port.
// master = lanes/memory side, slave = the arbiter.
interface lsu_mem_arbiter_if #(
    parameter int NUM_LANES = 2
);
    logic [NUM_LANES-1:0]    req, is_wr, gnt, rvalid;
    logic [NUM_LANES*32-1:0] addr, wdata;
    logic [31:0]             rdata, mem_addr, mem_wdata, mem_rdata;
    logic                    stall, flush, mem_wr_en, mem_rd_en;
    modport master (
        output req, is_wr, addr, wdata, flush, mem_rdata,
        input  gnt, rvalid, rdata, stall, mem_addr, mem_wdata, mem_wr_en, mem_rd_en
    );
    modport slave (
        input  req, is_wr, addr, wdata, flush, mem_rdata,
        output gnt, rvalid, rdata, stall, mem_addr, mem_wdata, mem_wr_en, mem_rd_en
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin share of one data-memory port among NUM_LANES LSU lanes.
// Define LSU_ARB_FIXED_PRIO_EN for fixed priority (lane 0 highest) instead of round-robin.
module lsu_mem_arbiter #(
    parameter int NUM_LANES = 2,
    parameter int LANE_W = $clog2(NUM_LANES)
) (
    input logic              clk,
    input logic              rst,
    lsu_mem_arbiter_if.slave bus
);
    logic [LANE_W-1:0] start, sel, rd_lane;
    logic              any, sel_wr, rd_pend;
    logic [31:0]       sel_addr, sel_wdata;

    always_comb begin
        int l;
        l = 0;
        any = 1'b0;
        sel = '0;
        sel_wr = 1'b0;
        sel_addr = '0;
        sel_wdata = '0;
        for (int o = 0; o < NUM_LANES; o++) begin
            l = (int'(start) + o) % NUM_LANES;
            if (!any && bus.req[l]) begin
                any = 1'b1;
                sel = LANE_W'(l);
                sel_wr = bus.is_wr[l];
                sel_addr = bus.addr[32*l +: 32];
                sel_wdata = bus.wdata[32*l +: 32];
            end
        end
    end

`ifdef LSU_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [LANE_W-1:0] rr_ptr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (any)
            rr_ptr <= LANE_W'((int'(sel) + 1) % NUM_LANES);
    end
    assign start = rr_ptr;
`endif

    // a flushed read still reaches memory but its response is never reported
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend <= 1'b0;
            rd_lane <= '0;
        end else begin
            rd_pend <= any && !sel_wr && !bus.flush;
            if (any && !sel_wr)
                rd_lane <= sel;
        end
    end

    assign bus.gnt       = any ? NUM_LANES'(1) << sel : '0;
    assign bus.rvalid    = (rd_pend && !bus.flush) ? NUM_LANES'(1) << rd_lane : '0;
    assign bus.rdata     = rd_pend ? bus.mem_rdata : '0;
    assign bus.stall     = |(bus.req & ~bus.gnt);
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.mem_wr_en = any && sel_wr;
    assign bus.mem_rd_en = any && !sel_wr;
endmodule
